resonator_dds_div_seq: RTL and testbench
========================================

# resonator_dds_div_seq

Iterative signed divider, the inverse companion of the DDS 16x16 signed multiplier. It takes a 32-bit signed dividend and a 16-bit signed divisor and produces a 16-bit signed quotient truncated toward zero, plus a 16-bit signed remainder. It uses a start/busy/done handshake with a fixed latency. Control logic in the resonator DDS uses it to rescale products back into 16-bit tone/phase-increment words, for example when computing per-resonator gain normalisation from accumulated products.

## Interface
Parameters:
- none; widths are fixed at 32/16/16/16.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- ce  in  1  clock enable; when 0, all registers (FSM, counter, datapath, outputs) hold
- start  in  1  request; sampled only in IDLE with ce=1
- dividend  in  32  signed numerator, captured on the accepting edge
- divisor  in  16  signed denominator, captured on the accepting edge
- busy  out  1  high from the accepting edge until the result edge
- done  out  1  result-valid strobe, one ce-enabled cycle
- quotient  out  16  signed, registered, held until the next result
- remainder  out  16  signed, registered, held until the next result
- div_by_zero  out  1  flag qualified by done, held with the result
- overflow  out  1  flag qualified by done, held with the result

## Operation
- FSM states: IDLE, CALC, SIGN.
- IDLE with start=1 and ce=1 (edge E0):
  - capture |dividend| as 32-bit unsigned (|-2^31| = 0x80000000 is exact) and |divisor| as 16-bit unsigned;
  - capture sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), and zero = (divisor==0);
  - load bit counter with 31, set busy=1, go to CALC.
- CALC: restoring radix-2 step, one quotient bit per ce-enabled cycle, MSB first.
  - 17-bit partial remainder; 32-bit magnitude quotient register.
  - After the step with counter==0 (edge E32), go to SIGN.
- SIGN (edge E33):
  - apply signs to the magnitudes;
  - saturate and register the outputs, set done=1, busy=0, go to IDLE.
- Result rules:
  - Truncation toward zero. Remainder takes the sign of the dividend, |remainder| < |divisor|, and dividend = q·divisor + r when no saturation occurs.
  - Overflow: if the signed true quotient is outside [-32768, 32767], quotient = 32767 (sign_q=0) or -32768 (sign_q=1), overflow=1. Remainder is still the exact value; it always fits in 16 bits.
  - Divide by zero: quotient = 32767 if dividend ≥ 0, else -32768. Remainder = 0, div_by_zero=1, overflow=0. Latency is unchanged (full CALC run, result overridden in SIGN).
- start while busy (CALC or SIGN) is ignored, with no queueing.
- done and flags clear on the next ce-enabled edge. quotient and remainder hold until overwritten.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately. No done is produced for the aborted request.
- Latency: done is high in the cycle after E33, i.e. 33 ce-enabled cycles after the accepting edge. With ce low for k cycles in between, latency is 33+k.
- busy is high for exactly 33 ce-enabled cycles and is low whenever done is high.
- Back-to-back operation: start may be asserted in the done cycle. It is accepted (FSM is IDLE), giving a throughput of 1 result per 34 ce-enabled cycles.
- With ce=0 while done=1, done stays high until the next ce-enabled edge.
- Inputs are only sampled at E0. dividend and divisor may change freely during busy.

## Test plan
- 1000 / 7 → quotient=142, remainder=6, flags 0; done exactly 33 cycles after the start edge; busy high 33 cycles.
- Sign matrix:
  - -1000 / 7 → -142, -6
  - 1000 / -7 → -142, 6
  - -1000 / -7 → 142, -6
  - 6 / 7 → 0, 6
- Saturation cases:
  - 0x7FFFFFFF / 1 → quotient=32767, overflow=1
  - -2^31 / -32768 → quotient=32767, overflow=1, remainder=0
  - -32768 / 1 → -32768, overflow=0
  - 32768 / -1 → -32768, overflow=0
  - 65535 / 2 → 32767, remainder=1
- Divide by zero:
  - 5 / 0 → quotient=32767, remainder=0, div_by_zero=1
  - -5 / 0 → quotient=-32768
  - both still complete in 33 cycles.
- Handshake:
  - start pulsed at cycles 5 and 20 during busy → ignored, and the original result is unchanged;
  - new start asserted in the done cycle → accepted, second done 34 cycles after the first.
- ce and reset:
  - ce held low for 5 cycles mid-CALC → done at 38 cycles, correct result;
  - reset asserted at cycle 10 of an operation → all outputs 0 immediately, no done; a subsequent 100 / 10 → 10, 0.

Source files
------------

// File: rtl/resonator_dds_div_seq.sv
`default_nettype none
// ============================================================================
// resonator_dds_div_seq : 32/16 signed restoring divider, 33-cycle latency
// Rev 1.0
// ============================================================================
module resonator_dds_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [15:0] r_rem;
  logic [31:0] r_quo;
  logic [15:0] r_den;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_zero;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic        r_ovf;
  logic [15:0] r_q;
  logic [15:0] r_r;

  logic [31:0] w_dvd_mag;
  logic [15:0] w_dvs_mag;
  logic [16:0] w_trial;
  logic        w_fits;
  logic [15:0] w_sub;
  logic [15:0] w_rem_next;
  logic        w_ovf;
  logic [15:0] w_q_signed;
  logic [15:0] w_r_signed;
  logic [15:0] w_q_sat;

  assign w_dvd_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign w_dvs_mag = divisor[15]  ? (~divisor + 16'd1)  : divisor;

  // Dividend bits shift out of the top of r_quo while quotient bits shift in.
  assign w_trial    = {r_rem, r_quo[31]};
  assign w_fits     = (w_trial >= {1'b0, r_den});
  // The difference is below the divisor, so the low 16 bits are exact.
  assign w_sub      = w_trial[15:0] - r_den;
  assign w_rem_next = w_fits ? w_sub : w_trial[15:0];

  assign w_ovf      = r_sign_q ? (r_quo > 32'd32768) : (r_quo > 32'd32767);
  assign w_q_signed = r_sign_q ? (~r_quo[15:0] + 16'd1) : r_quo[15:0];
  assign w_r_signed = r_sign_r ? (~r_rem + 16'd1) : r_rem;
  assign w_q_sat    = r_sign_q ? 16'h8000 : 16'h7FFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 5'd0) w_next = S_SIGN;
      S_SIGN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_rem    <= 16'd0;
      r_quo    <= 32'd0;
      r_den    <= 16'd0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_q      <= 16'd0;
      r_r      <= 16'd0;
    end else if (ce) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_quo    <= w_dvd_mag;
            r_rem    <= 16'd0;
            r_den    <= w_dvs_mag;
            r_sign_q <= dividend[31] ^ divisor[15];
            r_sign_r <= dividend[31];
            r_zero   <= (divisor == 16'd0);
            r_cnt    <= 5'd31;
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[30:0], w_fits};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        S_SIGN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_zero) begin
            r_q   <= r_sign_r ? 16'h8000 : 16'h7FFF;
            r_r   <= 16'd0;
            r_dbz <= 1'b1;
          end else begin
            r_q   <= w_ovf ? w_q_sat : w_q_signed;
            r_r   <= w_r_signed;
            r_ovf <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_resonator_dds_div_seq.sv
`default_nettype none
// Testbench for resonator_dds_div_seq: directed spec cases plus random ops vs an arithmetic model.
module tb_resonator_dds_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [15:0] divisor = 16'd0;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resonator_dds_div_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int c_dvd [12] = '{1000, -1000, 1000, -1000, 6, 32'h7FFF_FFFF, 32'h8000_0000,
                     -32768, 32768, 65535, 5, -5};
  int c_dvs [12] = '{7, 7, -7, -7, 7, 1, -32768, 1, -1, 2, 0, 0};
  int c_q   [12] = '{142, -142, -142, 142, 0, 32767, 32767, -32768, -32768, 32767, 32767, -32768};
  int c_r   [12] = '{6, -6, 6, -6, 6, 0, 0, 0, 0, 1, 0, 0};
  int c_ov  [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  int c_dz  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer division truncating toward zero, then saturate.
  function automatic void model(input logic [31:0] dvd, input logic [15:0] dvs,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov);
    longint a, b, tq, tr;
    a = longint'($signed(dvd));
    b = longint'($signed(dvs));
    if (b == 0) begin
      q = (a >= 0) ? 16'h7FFF : 16'h8000;
      r = 16'd0; dz = 1'b1; ov = 1'b0;
    end else begin
      tq = a / b;
      tr = a % b;
      dz = 1'b0; ov = 1'b0;
      if (tq > 32767) begin q = 16'h7FFF; ov = 1'b1; end
      else if (tq < -32768) begin q = 16'h8000; ov = 1'b1; end
      else q = tq[15:0];
      r = tr[15:0];
    end
  endfunction

  // Issues one request and waits (bounded) for done; lat counts all clock edges after acceptance.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input int stall_at,
                       input int stall_len, output int lat, output int bcnt, output logic bz);
    dividend = a; divisor = b; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
    lat = 0; bcnt = busy ? 1 : 0; bz = 1'b1;
    while (lat < 200) begin
      if (stall_len > 0 && lat == stall_at) ce = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) ce = 1'b1;
      tick();
      lat++;
      if (done) begin bz = busy; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    reset = 1'b0; ce = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int lat, bcnt;
    logic bz;
    logic [15:0] eq, er;
    for (int i = 0; i < 12; i++) begin
      do_op(c_dvd[i], 16'(c_dvs[i]), 0, 0, lat, bcnt, bz);
      eq = c_q[i][15:0];
      er = c_r[i][15:0];
      checks++;
      if (quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL directed_%0d result got q=%0d r=%0d, want q=%0d r=%0d",
                 i, $signed(quotient), $signed(remainder), $signed(eq), $signed(er));
      end
      checks++;
      if (overflow !== c_ov[i][0] || div_by_zero !== c_dz[i][0]) begin
        errors++;
        $display("FAIL directed_%0d flags got ov=%b dz=%b, want ov=%0d dz=%0d",
                 i, overflow, div_by_zero, c_ov[i], c_dz[i]);
      end
      checks++;
      if (lat !== 33 || bcnt !== 33 || bz !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d timing got lat=%0d busy_cycles=%0d busy_at_done=%b, want 33 33 0",
                 i, lat, bcnt, bz);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic bz, dz, ov;
    logic [31:0] a, rnd;
    logic [15:0] b, eq, er;
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 7))
        0:       begin a = $urandom; b = 16'd0; end
        1, 2:    begin a = $urandom; b = 16'($urandom); end
        3, 4, 5: begin a = {{8{rnd[23]}}, rnd[23:0]}; b = 16'($urandom); end
        default: begin a = {{16{rnd[15]}}, rnd[15:0]}; b = {{8{rnd[23]}}, rnd[23:16]}; end
      endcase
      model(a, b, eq, er, dz, ov);
      do_op(a, b, 0, 0, lat, bcnt, bz);
      checks++;
      if (quotient !== eq || remainder !== er || overflow !== ov || div_by_zero !== dz || lat !== 33) begin
        errors++;
        $display("FAIL random %h/%h got q=%h r=%h ov=%b dz=%b lat=%0d, want q=%h r=%h ov=%b dz=%b lat=33",
                 a, b, quotient, remainder, overflow, div_by_zero, lat, eq, er, ov, dz);
      end
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    dividend = 32'd1000; divisor = 16'd7; start = 1'b1; ce = 1'b1;
    tick();
    lat = 0;
    while (lat < 200) begin
      start = (lat == 5 || lat == 20);
      dividend = 32'hFFFF_FC19; divisor = 16'd3;
      tick();
      lat++;
      if (done) break;
    end
    start = 1'b0;
    checks++;
    if (lat !== 33 || quotient !== 16'd142 || remainder !== 16'd6) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d q=%0d r=%0d, want lat=33 q=142 r=6",
               lat, $signed(quotient), $signed(remainder));
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_no_queue got %0d busy/done cycles after result, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, c1;
    logic bz;
    do_op(32'd1000, 16'd7, 0, 0, lat, bcnt, bz);
    c1 = cyc;
    do_op(32'hFFFF_FC18, 16'hFFF9, 0, 0, lat, bcnt, bz);
    checks++;
    if (cyc - c1 !== 34 || quotient !== 16'd142 || remainder !== 16'hFFFA) begin
      errors++;
      $display("FAIL back_to_back got gap=%0d q=%0d r=%0d, want gap=34 q=142 r=-6",
               cyc - c1, $signed(quotient), $signed(remainder));
    end
    tick();
  endtask

  task automatic test_ce_stall();
    int lat, bcnt;
    logic bz, dz, ov;
    logic [15:0] eq, er;
    model(32'd123456, 16'hFEBF, eq, er, dz, ov);
    do_op(32'd123456, 16'hFEBF, 10, 5, lat, bcnt, bz);
    checks++;
    if (lat !== 38 || bcnt !== 38 || quotient !== eq || remainder !== er) begin
      errors++;
      $display("FAIL ce_stall got lat=%0d busy_cycles=%0d q=%h r=%h, want lat=38 busy=38 q=%h r=%h",
               lat, bcnt, quotient, remainder, eq, er);
    end
    ce = 1'b0;
    repeat (3) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold_ce got done=%b with ce low, want 1", done);
    end
    ce = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
      errors++;
      $display("FAIL done_clear got done=%b q=%h r=%h, want done=0 q=%h r=%h",
               done, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, seen;
    logic bz;
    dividend = 32'd5000; divisor = 16'd3; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 36'd0) begin
      errors++;
      $display("FAIL reset_abort got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d busy/done cycles, want 0", seen);
    end
    do_op(32'd100, 16'd10, 0, 0, lat, bcnt, bz);
    checks++;
    if (quotient !== 16'd10 || remainder !== 16'd0 || lat !== 33) begin
      errors++;
      $display("FAIL after_reset got q=%0d r=%0d lat=%0d, want q=10 r=0 lat=33",
               $signed(quotient), $signed(remainder), lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_ce_stall();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
